// File: rtl/io_display_pkg.sv
//------------------------------------------------------------------------------
// io_display_pkg : converter states, sizes and 7-segment codes.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package io_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

  localparam int BCD_DIGITS = 10;
  localparam int NUM_CH     = 3;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] i_digit);
    logic [6:0] r_code;
    case (i_digit)
      4'd0:    r_code = SEG_0;
      4'd1:    r_code = SEG_1;
      4'd2:    r_code = SEG_2;
      4'd3:    r_code = SEG_3;
      4'd4:    r_code = SEG_4;
      4'd5:    r_code = SEG_5;
      4'd6:    r_code = SEG_6;
      4'd7:    r_code = SEG_7;
      4'd8:    r_code = SEG_8;
      4'd9:    r_code = SEG_9;
      default: r_code = SEG_BLANK;
    endcase
    return r_code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_display_driver_if.sv
//------------------------------------------------------------------------------
// io_display_driver_if : channel words, select and display pins.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface io_display_driver_if;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [31:0] in3;
  logic [1:0]  sel;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        dp;
  logic        busy;
  logic        ovf;

  modport master (output in1, in2, in3, sel, input seg, an, dp, busy, ovf);
  modport slave  (input in1, in2, in3, sel, output seg, an, dp, busy, ovf);
endinterface

`default_nettype wire

// File: rtl/io_display_driver_bin2bcd_seq.sv
//------------------------------------------------------------------------------
// bin2bcd_seq : 32-bit sequential double-dabble, IDLE/LOAD/SHIFT/DONE. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
  import io_display_pkg::*;
(
  input  wire logic        clock,
  input  wire logic        resetn,
  input  wire logic        i_start,
  input  wire logic [31:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [39:0]      o_bcd
);

  conv_state_t r_state;
  logic [31:0] r_bin;
  logic [39:0] r_bcd;
  logic [4:0]  r_cnt;
  logic [39:0] w_adj;
  logic        w_unused;

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5)
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  // The top digit of a 32-bit value never exceeds 4, so its carry-out is dead.
  assign w_unused = w_adj[39];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) r_state <= LOAD;
        LOAD: begin
          r_bin   <= i_bin;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj[38:0], r_bin, 1'b0};
          r_cnt          <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != IDLE);
  assign o_done = (r_state == DONE);
  assign o_bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/io_display_driver.sv
//------------------------------------------------------------------------------
// io_display_driver : 3-channel BCD refresh + 8-digit 7-seg scan.  Rev 1.0
// Optional leading-zero blanking with `define IO_DISP_BLANK_EN.
//------------------------------------------------------------------------------
`default_nettype none

module io_display_driver
  import io_display_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int NUM_DIGITS = 8
)(
  input  wire logic          clock,
  input  wire logic          resetn,
  io_display_driver_if.slave disp
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [1:0]       r_ptr;
  logic [39:0]      r_bcd_buf [NUM_CH];
  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_idx;

  logic [31:0] w_bin;
  logic [39:0] w_bcd;
  logic        w_done;
  logic        w_busy;
  logic [39:0] w_sel_buf;
  logic        w_off;
  logic [3:0]  w_digit;
  logic        w_ovf;
  logic        w_blank;

  always_comb begin
    case (r_ptr)
      2'd1:    w_bin = disp.in2;
      2'd2:    w_bin = disp.in3;
      default: w_bin = disp.in1;
    endcase
  end

  bin2bcd_seq u_conv (
    .clock   (clock),
    .resetn  (resetn),
    .i_start (1'b1),
    .i_bin   (w_bin),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  assign disp.busy = w_busy;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= 2'd0;
      for (int ch = 0; ch < NUM_CH; ch++) r_bcd_buf[ch] <= '0;
    end else if (w_done) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        if (r_ptr == 2'(ch)) r_bcd_buf[ch] <= w_bcd;
      r_ptr <= (r_ptr == 2'(NUM_CH - 1)) ? 2'd0 : r_ptr + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_comb begin
    case (disp.sel)
      2'd0:    w_sel_buf = r_bcd_buf[0];
      2'd1:    w_sel_buf = r_bcd_buf[1];
      2'd2:    w_sel_buf = r_bcd_buf[2];
      default: w_sel_buf = '0;
    endcase
  end

  assign w_off   = (disp.sel == 2'd3);
  assign w_digit = w_sel_buf[{r_idx, 2'b00} +: 4];
  assign w_ovf   = !w_off && (w_sel_buf[39:32] != 8'd0);

`ifdef IO_DISP_BLANK_EN
  // Blank when this digit and every digit above it on the display is zero.
  always_comb begin
    w_blank = (r_idx != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) >= r_idx && w_sel_buf[4*k +: 4] != 4'd0)
        w_blank = 1'b0;
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      disp.an  <= 8'hFF;
      disp.seg <= SEG_BLANK;
      disp.dp  <= 1'b1;
      disp.ovf <= 1'b0;
    end else if (w_off) begin
      disp.an  <= 8'hFF;
      disp.seg <= SEG_BLANK;
      disp.dp  <= 1'b1;
      disp.ovf <= 1'b0;
    end else begin
      disp.an  <= ~(8'h01 << r_idx);
      disp.seg <= w_blank ? SEG_BLANK : seg_decode(w_digit);
      disp.dp  <= !((r_idx == IDX_W'(NUM_DIGITS - 1)) && w_ovf);
      disp.ovf <= w_ovf;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_io_display_driver.sv
//------------------------------------------------------------------------------
// tb_io_display_driver : directed self-checking bench, SCAN_DIV=4.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_display_driver;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

`ifdef IO_DISP_BLANK_EN
  localparam logic [6:0] BZ = 7'h7F;
`else
  localparam logic [6:0] BZ = 7'h40;
`endif

  // Expected segment codes, idx7 in the top slice down to idx0 in the bottom.
  localparam logic [55:0] EXP_1234 = {BZ, BZ, BZ, BZ, 7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [55:0] EXP_FFFF = {7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12};
  localparam logic [55:0] EXP_5    = {BZ, BZ, BZ, BZ, BZ, BZ, BZ, 7'h12};
  localparam logic [55:0] EXP_7    = {BZ, BZ, BZ, BZ, BZ, BZ, BZ, 7'h78};
  localparam logic [55:0] EXP_0    = {BZ, BZ, BZ, BZ, BZ, BZ, BZ, 7'h40};
  localparam logic [55:0] EXP_99   = {BZ, BZ, BZ, BZ, BZ, BZ, 7'h10, 7'h10};

  io_display_driver_if dif ();

  io_display_driver #(.SCAN_DIV(4), .NUM_DIGITS(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .disp   (dif)
  );

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic scan_check(input logic [55:0] exp, input logic exp_ovf,
                            input int n, input string name);
    int         idx;
    int         prev;
    int         run;
    bit         first_change;
    logic [7:0] pat;
    prev = -1;
    run  = 0;
    first_change = 1'b1;
    for (int s = 0; s < n; s++) begin
      @(negedge clock);
      idx = -1;
      for (int k = 0; k < 8; k++) begin
        pat = ~(8'h01 << k);
        if (dif.an == pat) idx = k;
      end
      checks++;
      if (idx < 0) begin
        failures++;
        $display("FAIL %s an: got %h, want single low bit", name, dif.an);
      end else begin
        checks++;
        if (dif.seg !== exp[idx*7 +: 7]) begin
          failures++;
          $display("FAIL %s seg idx%0d: got %h, want %h", name, idx, dif.seg, exp[idx*7 +: 7]);
        end
        checks++;
        if (dif.dp !== !(idx == 7 && exp_ovf)) begin
          failures++;
          $display("FAIL %s dp idx%0d: got %b, want %b", name, idx, dif.dp, !(idx == 7 && exp_ovf));
        end
        checks++;
        if (dif.ovf !== exp_ovf) begin
          failures++;
          $display("FAIL %s ovf: got %b, want %b", name, dif.ovf, exp_ovf);
        end
        if (prev >= 0 && idx != prev) begin
          checks++;
          if (idx != (prev + 1) % 8) begin
            failures++;
            $display("FAIL %s order: got idx%0d after idx%0d, want idx%0d", name, idx, prev, (prev + 1) % 8);
          end
          if (!first_change) begin
            checks++;
            if (run != 4) begin
              failures++;
              $display("FAIL %s hold idx%0d: got %0d cycles, want 4", name, prev, run);
            end
          end
          first_change = 1'b0;
          run = 0;
        end
        run++;
        prev = idx;
      end
    end
  endtask

  task automatic test_reset();
    dif.in1 = $urandom;
    dif.in2 = $urandom;
    dif.in3 = $urandom;
    dif.sel = 2'($urandom_range(0, 3));
    resetn  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (dif.an !== 8'hFF || dif.seg !== 7'h7F || dif.dp !== 1'b1 ||
          dif.busy !== 1'b0 || dif.ovf !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: got an=%h seg=%h dp=%b busy=%b ovf=%b, want FF 7F 1 0 0",
                 dif.an, dif.seg, dif.dp, dif.busy, dif.ovf);
      end
    end
    dif.sel = 2'd0;
    resetn  = 1'b1;
    @(negedge clock);
    checks++;
    if (dif.an !== 8'hFE || dif.seg !== 7'h40 || dif.dp !== 1'b1 || dif.ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got an=%h seg=%h dp=%b ovf=%b, want FE 40 1 0",
               dif.an, dif.seg, dif.dp, dif.ovf);
    end
    checks++;
    if (dif.busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_release busy: got %b, want 1", dif.busy);
    end
  endtask

  task automatic test_decimal();
    dif.in1 = 32'd1234;
    dif.in2 = 32'hFFFF_FFFF;
    dif.in3 = 32'd0;
    dif.sel = 2'd0;
    repeat (140) @(negedge clock);
    scan_check(EXP_1234, 1'b0, 40, "dec_1234");
  endtask

  task automatic test_overflow();
    dif.sel = 2'd1;
    scan_check(EXP_FFFF, 1'b1, 40, "ovf_ffffffff");
  endtask

  task automatic test_snapshot();
    dif.in1 = 32'd5;
    dif.sel = 2'd0;
    apply_reset();
    repeat (10) @(negedge clock);
    dif.in1 = 32'd7;
    repeat (25) @(negedge clock);
    scan_check(EXP_5, 1'b0, 32, "snap_old");
    repeat (77) @(negedge clock);
    scan_check(EXP_7, 1'b0, 32, "snap_new");
  endtask

  task automatic test_off();
    int nlow;
    int last_low;
    nlow = 0;
    last_low = -1;
    dif.sel = 2'd3;
    for (int c = 0; c < 70; c++) begin
      @(negedge clock);
      checks++;
      if (dif.an !== 8'hFF || dif.seg !== 7'h7F || dif.dp !== 1'b1 || dif.ovf !== 1'b0) begin
        failures++;
        $display("FAIL sel3_off: got an=%h seg=%h dp=%b ovf=%b, want FF 7F 1 0",
                 dif.an, dif.seg, dif.dp, dif.ovf);
      end
      if (dif.busy === 1'b0) begin
        if (last_low >= 0) begin
          checks++;
          if (c - last_low != 35) begin
            failures++;
            $display("FAIL sel3_busy_period: got %0d, want 35", c - last_low);
          end
        end
        last_low = c;
        nlow++;
      end
    end
    checks++;
    if (nlow != 2) begin
      failures++;
      $display("FAIL sel3_busy_idle_count: got %0d, want 2", nlow);
    end
  endtask

  task automatic test_reset_mid_shift();
    dif.in1 = 32'd99;
    dif.sel = 2'd0;
    apply_reset();
    repeat (20) @(negedge clock);
    resetn = 1'b0;
    #1;
    checks++;
    if (dif.an !== 8'hFF || dif.seg !== 7'h7F || dif.dp !== 1'b1 ||
        dif.busy !== 1'b0 || dif.ovf !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: got an=%h seg=%h dp=%b busy=%b ovf=%b, want FF 7F 1 0 0",
               dif.an, dif.seg, dif.dp, dif.busy, dif.ovf);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (dif.busy !== 1'b1 || dif.an !== 8'hFE || dif.seg !== 7'h40) begin
      failures++;
      $display("FAIL abort_restart: got busy=%b an=%h seg=%h, want 1 FE 40",
               dif.busy, dif.an, dif.seg);
    end
    scan_check(EXP_0, 1'b0, 31, "abort_buf_kept");
    repeat (3) @(negedge clock);
    scan_check(EXP_99, 1'b0, 32, "abort_reconvert");
  endtask

  initial begin
    dif.in1 = '0;
    dif.in2 = '0;
    dif.in3 = '0;
    dif.sel = 2'd0;
    test_reset();
    test_decimal();
    test_overflow();
    test_snapshot();
    test_off();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/io_display_driver.md
Name: io_display_driver

Overview:
Receiving end of the processor's output port. It consumes the three 32-bit output words (out1..out3 of the processing unit) and shows one of them, in decimal, on an 8-digit multiplexed 7-segment display. A sequential double-dabble converter refreshes the channels round-robin into a BCD buffer. An independent scan counter drives the digit anodes and segments.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays enabled (must be >= 2)
NUM_DIGITS, 8, physical digits scanned (fixed at 8 for this revision)

Ports:
clock  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
in1  input  32  channel 0 word (processor out1)
in2  input  32  channel 1 word (processor out2)
in3  input  32  channel 2 word (processor out3)
sel  input  2  displayed channel: 0..2 select in1..in3; 3 = display off
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  8  digit anodes, active-low; an[0] is the rightmost digit
dp  output  1  decimal point, active-low
busy  output  1  converter not in IDLE
ovf  output  1  selected value >= 100000000 (cannot be shown in 8 digits)

Behaviour:
- Clock and reset are fixed: one clock, clock; asynchronous active-low reset, resetn.
- Reset values: FSM=IDLE, channel pointer=0, all BCD buffers=0, scan divider=0, digit index=0, an=8'hFF, seg=7'h7F, dp=1, busy=0, ovf=0.
- Converter FSM states: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE: lasts one cycle, then go to LOAD.
- LOAD: snapshot in[ptr] into a 32-bit shift register; clear the 40-bit BCD accumulator; clear the iteration count.
- SHIFT: one iteration per cycle, 32 iterations. Each iteration adds 3 to every nibble >= 5, then shifts {bcd,bin} left by 1.
- DONE: write the 10 digits to bcd_buf[ptr]; advance ptr 0->1->2->0.
- Timing: one channel takes 35 cycles (IDLE 1, LOAD 1, SHIFT 32, DONE 1). Any input change is reflected in its buffer within 140 cycles.
- Input changes after LOAD do not affect the running conversion. The new value is picked up on that channel's next pass.
- busy=1 in LOAD, SHIFT and DONE.
- Scan divider counts 0..SCAN_DIV-1. On wrap, the digit index increments 7->0.
- Registered outputs: an = ~(1<<idx); seg = decode(bcd_buf[sel][idx]); dp=0 only when idx=7 and ovf=1.
- sel=3: an=8'hFF, seg=7'h7F, dp=1.
- A sel change takes effect on the next clock edge.
- ovf = (BCD digits 9 or 8 of the selected buffer != 0), registered. ovf=0 when sel=3.
- Segment decode, digits 0..9: 40,79,24,30,19,12,02,78,00,10 (hex). Codes >9 cannot occur; decode them as 7F.
- resetn asserted mid-conversion aborts immediately to reset values. The buffer being converted is not written.

Optional Feature:
IO_DISP_BLANK_EN.
- Defined: leading-zero blanking. A digit idx>0 whose value and all higher displayed digits are 0 drives seg=7'h7F, with the anode still enabled. Digit 0 is always shown, so value 0 shows a single "0".
- Undefined: all 8 digits always shown, with zero padding.

Decomposition:
- Package io_display_pkg: converter state enum (IDLE, LOAD, SHIFT, DONE); BCD_DIGITS=10; NUM_CH=3; 7-segment code constants SEG_0..SEG_9 and SEG_BLANK.
- Sub-module bin2bcd_seq: 32-bit sequential double-dabble converter with a start/done handshake. It contains the LOAD/SHIFT/DONE path and a 40-bit result.
- Top level keeps the round-robin pointer, BCD buffers, scan logic and decode.

Test Plan:
1. Reset: hold resetn=0 with random inputs -> an=FF, seg=7F, dp=1, busy=0, ovf=0. Release resetn -> next cycle an=FE, seg=40.
2. SCAN_DIV=4, in1=1234, sel=0; wait 140 cycles -> idx0..7 show seg 19,30,24,79,40,40,40,40 (40 becomes 7F on idx4..7 with IO_DISP_BLANK_EN); ovf=0. Each digit holds 4 cycles; idx wraps 7->0.
3. in2=FFFFFFFF, sel=1 -> digits "94967295", ovf=1, dp=0 only while an=7F (idx 7).
4. Snapshot: change in1 from 5 to 7 while the FSM is in SHIFT for ptr=0 -> buffer shows 5 after DONE; shows 7 after the following ptr=0 pass.
5. sel=3 -> an=FF, seg=7F, dp=1, ovf=0 while the converter keeps cycling (busy toggles with its 35-cycle pattern).
6. Pull resetn low mid-SHIFT, then release -> reset values; bcd_buf[ptr] is unchanged (still 0); conversion restarts at ptr=0.
